// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared constants and types for the UART menu-key command decoder.
//   - ASCII constants for the characters the decoder cares about
//   - cmd_code_t : 3-bit command code, CMD_MENU1..CMD_TOG2 = 1..7
//                  (CMD_NONE = 0 is only ever seen as the reset value)
//   - S_EMPTY / S_HOLD : output-stage FSM state encoding
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_0  = 8'h30;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_MENU1 = 3'd1,
        CMD_MENU2 = 3'd2,
        CMD_MENU3 = 3'd3,
        CMD_MENU4 = 3'd4,
        CMD_MENU5 = 3'd5,
        CMD_TOG1  = 3'd6,
        CMD_TOG2  = 3'd7
    } cmd_code_t;

    localparam logic S_EMPTY = 1'b0;
    localparam logic S_HOLD  = 1'b1;

endpackage

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous register FIFO, 2^FIFO_W entries of DW bits, with a
// combinational read port (o_rd_data always shows the head entry).
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_wr_en      : push i_wr_data (accepted when not full, or when a pop
//                  happens in the same cycle)
//   i_rd_en      : pop the head entry (ignored when empty)
//   o_rd_data    : head entry
//   o_full       : level == 2^FIFO_W
//   o_empty      : level == 0
//   o_level      : number of stored entries
// -----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int FIFO_W = 2,
    parameter int DW     = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_wr_en,
    input  logic [DW-1:0]   i_wr_data,
    input  logic            i_rd_en,
    output logic [DW-1:0]   o_rd_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [FIFO_W:0] o_level
);

    localparam int DEPTH = 1 << FIFO_W;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [FIFO_W:0] r_wr_ptr;
    logic [FIFO_W:0] r_rd_ptr;
    logic            w_push;
    logic            w_pop;

    // Pointers carry one extra wrap bit so a full FIFO and an empty FIFO
    // are told apart by the plain difference.
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_level == (FIFO_W+1)'(DEPTH));
    assign o_empty   = (o_level == '0);
    assign o_rd_data = r_mem[r_rd_ptr[FIFO_W-1:0]];

    assign w_pop  = i_rd_en && !o_empty;
    assign w_push = i_wr_en && (!o_full || w_pop);

    // When full, a simultaneous push and pop address the same slot; the
    // head is read combinationally before the edge, so the new entry
    // safely overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[FIFO_W-1:0]] <= i_wr_data;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// -----------------------------------------------------------------------------
// uart_cmd_decoder
// Filters bytes from uart_rx, decodes ASCII keys '1'..CMD_MAX into 3-bit
// command codes, buffers them in a FIFO and presents them to the menu
// controller on a valid/ready handshake. Total storage is the FIFO plus
// one output register.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   rx_done_tick  : one-cycle strobe, rx_data valid
//   rx_data       : received byte
//   cmd_ready     : controller takes cmd_code this cycle
//   ovf_clr       : synchronous clear of the sticky overflow flag
//   cmd_valid     : cmd_code holds a pending command
//   cmd_code      : decoded command (held while cmd_valid is low)
//   cmd_err       : one-cycle pulse after an invalid character
//   ovf           : sticky, a command was dropped because storage was full
//   fifo_level    : FIFO occupancy, not counting the output register
// -----------------------------------------------------------------------------
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int FIFO_W  = 2,
    parameter int CMD_MAX = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_done_tick,
    input  logic [DBIT-1:0] rx_data,
    input  logic            cmd_ready,
    input  logic            ovf_clr,
    output logic            cmd_valid,
    output logic [2:0]      cmd_code,
    output logic            cmd_err,
    output logic            ovf,
    output logic [FIFO_W:0] fifo_level
);

    localparam logic [DBIT-1:0] L_CR     = DBIT'(ASC_CR);
    localparam logic [DBIT-1:0] L_LF     = DBIT'(ASC_LF);
    localparam logic [DBIT-1:0] L_SP     = DBIT'(ASC_SP);
    localparam logic [DBIT-1:0] L_CMD_LO = DBIT'(ASC_0 + 8'd1);
    localparam logic [DBIT-1:0] L_CMD_HI = DBIT'(ASC_0 + 8'(CMD_MAX));

    logic       r_state;
    logic [2:0] r_code;
    logic       r_err;
    logic       r_ovf;

    logic       w_is_ws;
    logic       w_is_cmd;
    cmd_code_t  w_code;
    logic       w_wr_req;
    logic       w_wr_en;
    logic       w_drop;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [2:0] w_rd_data;

    // Byte classification. ASCII '0' has zero low bits, so the low three
    // bits of an accepted digit are already its numeric value.
    assign w_is_ws  = (rx_data == L_CR) || (rx_data == L_LF) || (rx_data == L_SP);
    assign w_is_cmd = (rx_data >= L_CMD_LO) && (rx_data <= L_CMD_HI);
    assign w_code   = cmd_code_t'(rx_data[2:0]);
    assign w_wr_req = rx_done_tick && w_is_cmd;

    // The output register refills whenever it is free or being consumed.
    assign w_pop   = !w_empty && ((r_state == S_EMPTY) || cmd_ready);
    assign w_wr_en = w_wr_req && (!w_full || w_pop);
    assign w_drop  = w_wr_req && !w_wr_en;

    cmd_fifo #(
        .FIFO_W (FIFO_W),
        .DW     (3)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_code),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );

    // Output stage: a pop always lands in the output register and leaves
    // the FSM in HOLD; a consumed command with nothing behind it returns
    // to EMPTY. cmd_code keeps its last value while EMPTY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_code  <= CMD_NONE;
        end else if (w_pop) begin
            r_state <= S_HOLD;
            r_code  <= w_rd_data;
        end else if ((r_state == S_HOLD) && cmd_ready) begin
            r_state <= S_EMPTY;
        end
    end

    // Error pulse and sticky overflow; a new drop outranks a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_err <= rx_done_tick && !w_is_ws && !w_is_cmd;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign cmd_valid = (r_state == S_HOLD);
    assign cmd_code  = r_code;
    assign cmd_err   = r_err;
    assign ovf       = r_ovf;

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Sits between uart_rx (rx_done_tick/dout) and the menu controller FSM. It filters and decodes received ASCII menu keys into 3-bit command codes and buffers them in a small FIFO. It hands commands over on a valid/ready handshake, so keystrokes typed while the controller is streaming ROM text are not lost. It also flags invalid characters and buffer overflow.

Parameters:
DBIT, 8, received word width; must match uart_rx DBIT.
FIFO_W, 2, FIFO address bits; the FIFO holds 2^FIFO_W codes.
CMD_MAX, 7, highest accepted key digit; accepted keys are '1'..CMD_MAX (1 <= CMD_MAX <= 7).

Ports:
clk  in  1  system clock (100 MHz domain shared with uart_rx).
reset  in  1  asynchronous, active-high reset.
rx_done_tick  in  1  one-cycle strobe from uart_rx: rx_data is valid.
rx_data  in  DBIT  received byte.
cmd_ready  in  1  controller accepts cmd_code this cycle.
ovf_clr  in  1  synchronous clear of the sticky overflow flag.
cmd_valid  out  1  cmd_code holds a pending command.
cmd_code  out  3  decoded command, 1..CMD_MAX.
cmd_err  out  1  one-cycle pulse: an invalid character was received.
ovf  out  1  sticky: a valid command was dropped because storage was full.
fifo_level  out  FIFO_W+1  entries in the FIFO, excluding the output register.

Behaviour:
- Reset (async assert, sync release): FIFO pointers 0, fifo_level 0, cmd_valid 0, cmd_code 0, cmd_err 0, ovf 0.
- Classification happens on the cycle rx_done_tick=1:
  - 0x0D, 0x0A, 0x20: discarded silently. No write, no err.
  - 0x31..(0x30+CMD_MAX): code = rx_data - 0x30 (low 3 bits). Write request.
  - Anything else: cmd_err=1 on the following cycle only. No write.
- Write rule: accept when FIFO not full, or when a FIFO pop occurs in the same cycle. Otherwise drop the code and set ovf=1.
- ovf is cleared only by ovf_clr or reset. If ovf_clr and a new drop coincide, ovf stays set (set wins).
- Output stage, 2-state FSM:
  - EMPTY: cmd_valid=0. If FIFO is non-empty, pop into cmd_code and go to HOLD.
  - HOLD: cmd_valid=1, cmd_code stable. On cmd_ready=1: if FIFO is non-empty, pop the next code (stay HOLD, back-to-back, one command per cycle); else go to EMPTY.
  - cmd_ready while EMPTY is ignored.
- Bypass: when EMPTY and the FIFO is empty, a write goes through the FIFO.
  - rx_done_tick sampled at edge E0 → FIFO write at E0, pop at E1.
  - cmd_valid is high after E1; first-key latency is 2 clocks.
- Total capacity is 2^FIFO_W + 1 commands (FIFO plus output register).
- Order is strictly FIFO; pointers wrap modulo 2^FIFO_W.
- fifo_level = wr_ptr - rd_ptr, using an FIFO_W+1-bit pointer scheme. Full when level == 2^FIFO_W.
- cmd_code holds its last value while EMPTY; do not rely on it when cmd_valid=0.
- Reset mid-operation discards all buffered commands immediately. No partial handshake survives.

Decomposition:
- Package uart_cmd_pkg holds:
  - ASCII constants ASC_CR=8'h0D, ASC_LF=8'h0A, ASC_SP=8'h20, ASC_0=8'h30.
  - The command code type (3 bits) and its enumerants CMD_MENU1..CMD_TOG2 = 1..7.
  - Output FSM state encoding S_EMPTY/S_HOLD.
- One sub-module, cmd_fifo: synchronous 2^FIFO_W x 3 register FIFO with wr_en, rd_en, full, empty, level and async active-high reset.
- Classification, overflow logic and the output FSM live in uart_cmd_decoder.

Test Plan:
- Assert reset, release; drive rx_data 0x33 with a 1-cycle rx_done_tick, cmd_ready=0 → cmd_valid=1, cmd_code=3 exactly 2 clocks later; holds until cmd_ready=1, then cmd_valid=0 next cycle.
- Send 0x0D, 0x0A, 0x20 → no cmd_valid, no cmd_err, fifo_level stays 0. Send 0x41 → cmd_err high for exactly 1 cycle, nothing queued.
- FIFO_W=2, cmd_ready=0, send '1','2','3','4','5','6' → cmd_code=1 held, fifo_level=4, ovf=1 after the 6th byte. Then hold cmd_ready=1 → codes 1,2,3,4,5 on consecutive cycles; '6' never appears.
- FIFO full with cmd_ready=1 in the same cycle as rx_done_tick carrying '7' → no drop, ovf stays 0, 7 delivered last.
- ovf_clr pulse coincident with a drop → ovf remains 1. A later lone ovf_clr → ovf=0.
- Queue three commands, assert reset for 1 cycle mid-transfer → cmd_valid=0 and fifo_level=0 immediately. A subsequent '2' is delivered with 2-clock latency.
